mcu_fsm: RTL and testbench
==========================

# mcu_fsm

Main control unit sequencer for the single-issue RISC-V core. Walks each instruction through fetch, decode, optional load/store access and writeback, and drives the 3-bit state bus consumed by the instruction decode unit. Also handles the instruction-memory and LSU valid/ready handshakes, counts retired instructions, and halts on illegal opcodes or bus timeouts.

## Interface
- TIMEOUT_CYCLES, 255: max cycles any handshake state may wait before halting; legal range 1..65535.
- RETIRE_W, 32: width of the retired-instruction counter.

- MCU_CLOCK  in  1  core clock, all logic rising-edge.
- MCU_RESET_InLow  in  1  reset, asynchronous assert, active-low.
- MCU_Opcode_InBUS  in  7  instruction bits [6:0] from the instruction register; sampled only in DECODE.
- MCU_Imem_Req_Ready  in  1  instruction memory accepts the fetch request.
- MCU_Imem_Rsp_Valid  in  1  fetched instruction word is present.
- MCU_Lsu_Req_Ready  in  1  LSU accepts the load/store request.
- MCU_Lsu_Rsp_Valid  in  1  LSU access complete.
- MCU_State_OutBUS  out  3  current state encoding, fed to the decode unit.
- MCU_Imem_Req_Valid  out  1  fetch request.
- MCU_Ir_Load  out  1  one-cycle load strobe for the instruction register.
- MCU_Lsu_Req_Valid  out  1  LSU request.
- MCU_Pc_Write  out  1  one-cycle PC update strobe.
- MCU_Retire  out  1  one-cycle retire strobe.
- MCU_Retire_Count_OutBUS  out  RETIRE_W  retired-instruction count.
- MCU_Halt  out  1  core halted (sticky).
- MCU_Halt_Cause_OutBUS  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 LSU timeout.

## Operation
- States and encodings are fixed because the decode unit decodes them:
  - RESET 000
  - FETCH_REQ 001
  - FETCH_WAIT 010
  - DECODE 011
  - MEM_REQ 100
  - MEM_WAIT 101
  - WRITEBACK 110
  - HALT 111
- Transitions:
  - RESET always goes to FETCH_REQ on the next clock.
  - FETCH_REQ: MCU_Imem_Req_Valid=1. On Req_Ready, go to FETCH_WAIT.
  - FETCH_WAIT: on Rsp_Valid, MCU_Ir_Load=1 (combinational, that cycle) and go to DECODE.
  - DECODE: classify the opcode.
    - 0000011 (load) or 0100011 (store): go to MEM_REQ.
    - 0110111, 0010111, 1101111, 1100111, 1100011, 0010011, 0110011: go to WRITEBACK.
    - Any other opcode: go to HALT with cause 01.
  - MEM_REQ: MCU_Lsu_Req_Valid=1. On Req_Ready, go to MEM_WAIT.
  - MEM_WAIT: on Lsu_Rsp_Valid, go to WRITEBACK.
  - WRITEBACK: MCU_Pc_Write=1 and MCU_Retire=1. Retire counter +1, wrapping modulo 2^RETIRE_W. Go to FETCH_REQ.
  - HALT: stays in HALT until reset. MCU_Halt=1; cause is held.
- Valid handshake rules:
  - Req_Valid, once raised, stays high until the cycle Ready is seen. It is never withdrawn.
  - A Rsp_Valid arriving in the same cycle as Req_Ready is ignored. The response is only sampled in the *_WAIT states.
- Timeout counter (16-bit):
  - Cleared on every state change.
  - Increments each cycle spent in FETCH_REQ, FETCH_WAIT, MEM_REQ or MEM_WAIT without the awaited Ready/Valid.
  - When the count equals TIMEOUT_CYCLES-1 and the awaited signal is still low, the next state is HALT.
    - Cause 10 if the timeout happened in a fetch state.
    - Cause 11 if it happened in a MEM state.
  - If the awaited signal arrives in the timeout cycle, the handshake wins and no halt occurs.
- All other outputs are Moore decodes of the state register: 0 outside their state.

## Timing
- Reset values:
  - State 000.
  - All strobes and valids 0.
  - Retire count 0, MCU_Halt 0, cause 00, timeout counter 0.
- Reset is asynchronous. Asserting it mid-transaction forces RESET immediately and drops Req_Valid in the same cycle. The first FETCH_REQ is the second rising edge after deassertion.
- Minimum instruction latency with zero-wait memories (Ready/Valid always 1):
  - Non-memory instruction: 4 cycles (001, 010, 011, 110).
  - Load/store: 6 cycles.
- The retire count updates on the clock edge ending WRITEBACK, so the new value is visible the cycle after MCU_Retire.
- MCU_Ir_Load depends combinationally on Imem_Rsp_Valid. No other output does.

## Test plan
- Zero-wait memories, program ADDI, LW, SW, JAL -> state sequence 001,010,011,110 for ADDI and JAL; 001,010,011,100,101,110 for LW and SW. Retire count reaches 4 after 20 cycles from the first FETCH_REQ.
- Imem_Req_Ready held low 3 cycles, then high -> Imem_Req_Valid stays 1 for 4 consecutive cycles; no halt.
- Opcode 1110011 in DECODE -> next state 111, MCU_Halt=1, cause 01; state held for 100 cycles despite any input activity.
- TIMEOUT_CYCLES=4, Lsu_Rsp_Valid never asserted -> 4 cycles in MEM_WAIT, then HALT with cause 11.
- TIMEOUT_CYCLES=4, Lsu_Rsp_Valid asserted in the 4th MEM_WAIT cycle -> WRITEBACK, no halt.
- Reset pulsed low during MEM_REQ -> Lsu_Req_Valid falls without waiting for a clock. State 000, count 0, cause 00. Normal fetch resumes afterwards.
- Retire count preloaded near 2^RETIRE_W-1 (RETIRE_W=4, 16 retirements) -> wraps from 15 to 0.

Source files
------------

// File: rtl/mcu_fsm_if.sv
// ----------------------------------------------------------------------------
// mcu_fsm_if
// Handshake and status bundle between the main control unit sequencer and
// the rest of the core (instruction memory, LSU, decode unit, PC/IR logic).
//
// Signals:
//   opcode          instruction bits [6:0] from the instruction register
//   imem_req_ready  instruction memory accepts the fetch request
//   imem_rsp_valid  fetched instruction word is present
//   lsu_req_ready   LSU accepts the load/store request
//   lsu_rsp_valid   LSU access complete
//   state           3-bit sequencer state, decoded by the decode unit
//   imem_req_valid  fetch request
//   ir_load         one-cycle instruction-register load strobe
//   lsu_req_valid   LSU request
//   pc_write        one-cycle PC update strobe
//   retire          one-cycle retire strobe
//   retire_count    retired-instruction counter (RETIRE_W bits)
//   halt            core halted, sticky until reset
//   halt_cause      00 none, 01 illegal opcode, 10 imem timeout, 11 LSU timeout
//
// Modports:
//   master  the sequencer side (drives state and strobes)
//   slave   the environment side (drives opcode and memory handshakes)
// ----------------------------------------------------------------------------
interface mcu_fsm_if #(
    parameter int RETIRE_W = 32
);
    logic [6:0]          opcode;
    logic                imem_req_ready;
    logic                imem_rsp_valid;
    logic                lsu_req_ready;
    logic                lsu_rsp_valid;
    logic [2:0]          state;
    logic                imem_req_valid;
    logic                ir_load;
    logic                lsu_req_valid;
    logic                pc_write;
    logic                retire;
    logic [RETIRE_W-1:0] retire_count;
    logic                halt;
    logic [1:0]          halt_cause;

    modport master (
        input  opcode,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  lsu_req_ready,
        input  lsu_rsp_valid,
        output state,
        output imem_req_valid,
        output ir_load,
        output lsu_req_valid,
        output pc_write,
        output retire,
        output retire_count,
        output halt,
        output halt_cause
    );

    modport slave (
        output opcode,
        output imem_req_ready,
        output imem_rsp_valid,
        output lsu_req_ready,
        output lsu_rsp_valid,
        input  state,
        input  imem_req_valid,
        input  ir_load,
        input  lsu_req_valid,
        input  pc_write,
        input  retire,
        input  retire_count,
        input  halt,
        input  halt_cause
    );
endinterface

// File: rtl/mcu_fsm.sv
// ----------------------------------------------------------------------------
// mcu_fsm
// Main control unit sequencer of the single-issue RISC-V core. Walks every
// instruction through fetch, decode, an optional load/store access and
// writeback; runs the imem and LSU valid/ready handshakes, counts retired
// instructions and halts on an illegal opcode or a handshake timeout.
//
// Parameters:
//   TIMEOUT_CYCLES  max cycles a handshake state may wait (1..65535)
//   RETIRE_W        width of the retired-instruction counter
//
// Ports:
//   clk    core clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mcu_fsm_if.master, handshakes, strobes and status
// ----------------------------------------------------------------------------
module mcu_fsm #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RETIRE_W       = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    mcu_fsm_if.master bus
);

    // Encodings are decoded externally by the decode unit, so they are fixed.
    typedef enum logic [2:0] {
        ST_RESET      = 3'b000,
        ST_FETCH_REQ  = 3'b001,
        ST_FETCH_WAIT = 3'b010,
        ST_DECODE     = 3'b011,
        ST_MEM_REQ    = 3'b100,
        ST_MEM_WAIT   = 3'b101,
        ST_WRITEBACK  = 3'b110,
        ST_HALT       = 3'b111
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_LSU     = 2'b11;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          cause_q;
    logic [1:0]          cause_d;
    logic [15:0]         tmo_q;
    logic                tmo_hit;
    logic                waiting;
    logic                released_q;
    logic [RETIRE_W-1:0] retire_cnt_q;

    assign tmo_hit = (tmo_q == TMO_LAST);
    assign waiting = (state_q == ST_FETCH_REQ) || (state_q == ST_FETCH_WAIT) ||
                     (state_q == ST_MEM_REQ)   || (state_q == ST_MEM_WAIT);

    // Next-state logic. Each handshake state advances when its awaited
    // signal is seen; otherwise it halts once the wait counter reaches the
    // last allowed cycle. The handshake is tested first so a signal arriving
    // in the timeout cycle still wins.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_RESET: begin
                // Hold RESET for the first edge after release so FETCH_REQ
                // appears on the second rising edge.
                if (released_q) begin
                    state_d = ST_FETCH_REQ;
                end
            end
            ST_FETCH_REQ: begin
                if (bus.imem_req_ready) begin
                    state_d = ST_FETCH_WAIT;
                end else if (tmo_hit) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_IMEM;
                end
            end
            ST_FETCH_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    state_d = ST_DECODE;
                end else if (tmo_hit) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_IMEM;
                end
            end
            ST_DECODE: begin
                case (bus.opcode)
                    7'b0000011, 7'b0100011: state_d = ST_MEM_REQ;
                    7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                    7'b1100011, 7'b0010011, 7'b0110011: state_d = ST_WRITEBACK;
                    default: begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_MEM_REQ: begin
                if (bus.lsu_req_ready) begin
                    state_d = ST_MEM_WAIT;
                end else if (tmo_hit) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_LSU;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.lsu_rsp_valid) begin
                    state_d = ST_WRITEBACK;
                end else if (tmo_hit) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_LSU;
                end
            end
            ST_WRITEBACK: state_d = ST_FETCH_REQ;
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_RESET;
        endcase
    end

    // State, halt cause, wait counter and retire counter. The wait counter
    // restarts on every state change and only advances while a handshake
    // state is stalled, so it always measures the current wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RESET;
            cause_q      <= CAUSE_NONE;
            tmo_q        <= '0;
            released_q   <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            released_q <= 1'b1;
            if (state_d != state_q) begin
                tmo_q <= '0;
            end else if (waiting) begin
                tmo_q <= tmo_q + 16'd1;
            end
            if (state_q == ST_WRITEBACK) begin
                retire_cnt_q <= retire_cnt_q + RETIRE_W'(1);
            end
        end
    end

    // Moore decodes of the state register; only ir_load looks at an input.
    assign bus.state          = state_q;
    assign bus.imem_req_valid = (state_q == ST_FETCH_REQ);
    assign bus.ir_load        = (state_q == ST_FETCH_WAIT) && bus.imem_rsp_valid;
    assign bus.lsu_req_valid  = (state_q == ST_MEM_REQ);
    assign bus.pc_write       = (state_q == ST_WRITEBACK);
    assign bus.retire         = (state_q == ST_WRITEBACK);
    assign bus.retire_count   = retire_cnt_q;
    assign bus.halt           = (state_q == ST_HALT);
    assign bus.halt_cause     = cause_q;

endmodule

// File: tb/tb_mcu_fsm.sv
// ----------------------------------------------------------------------------
// tb_mcu_fsm
// Self-checking bench for mcu_fsm with TIMEOUT_CYCLES=4 and RETIRE_W=4.
// A behavioural model tracks which pipeline step the core is in and is
// compared against every output on each falling edge; directed sequences
// pin the model with hand-computed literal expectations, then a randomized
// run exercises stalls, illegal opcodes and timeouts.
// ----------------------------------------------------------------------------
module tb_mcu_fsm;

    localparam int TMO = 4;
    localparam int RW  = 4;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Model: current step (numbered as the state bus), cycles spent in it,
    // halt cause, retirements modulo 2^RW, and whether one edge has passed
    // since reset release.
    int m_st    = 0;
    int m_wait  = 0;
    int m_cause = 0;
    int m_ret   = 0;
    bit m_rel   = 1'b0;

    logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111,
                                  7'b1101111, 7'b1100111, 7'b1100011, 7'b0010011,
                                  7'b0110011};

    mcu_fsm_if #(.RETIRE_W(RW)) bus ();

    mcu_fsm #(.TIMEOUT_CYCLES(TMO), .RETIRE_W(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic imem_rdy, input logic imem_vld,
                                 input logic lsu_rdy, input logic lsu_vld);
        bus.opcode         = op;
        bus.imem_req_ready = imem_rdy;
        bus.imem_rsp_valid = imem_vld;
        bus.lsu_req_ready  = lsu_rdy;
        bus.lsu_rsp_valid  = lsu_vld;
    endtask

    // Opcode classes straight from the instruction set: memory, other legal.
    function automatic bit isMemOp(input logic [6:0] op);
        return (op == 7'b0000011) || (op == 7'b0100011);
    endfunction

    function automatic bit isLegalOp(input logic [6:0] op);
        bit hit = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (legal_ops[i] == op) hit = 1'b1;
        end
        return hit;
    endfunction

    // The signal each handshake step is waiting for.
    function automatic logic awaitedSeen(input int st);
        case (st)
            1:       return bus.imem_req_ready;
            2:       return bus.imem_rsp_valid;
            4:       return bus.lsu_req_ready;
            default: return bus.lsu_rsp_valid;
        endcase
    endfunction

    // Behavioural model: handshake steps move one step forward when their
    // signal is seen, or halt after TMO stalled cycles.
    always @(posedge clk or negedge rst_n) begin : model
        int nxt;
        int cause;
        if (!rst_n) begin
            m_st    <= 0;
            m_wait  <= 0;
            m_cause <= 0;
            m_ret   <= 0;
            m_rel   <= 1'b0;
        end else begin
            nxt   = m_st;
            cause = m_cause;
            if (m_st == 0) begin
                if (m_rel) nxt = 1;
            end else if (m_st == 1 || m_st == 2 || m_st == 4 || m_st == 5) begin
                if (awaitedSeen(m_st) === 1'b1) begin
                    nxt = m_st + 1;
                end else if (m_wait + 1 >= TMO) begin
                    nxt   = 7;
                    cause = (m_st < 4) ? 2 : 3;
                end
            end else if (m_st == 3) begin
                if (isMemOp(bus.opcode)) nxt = 4;
                else if (isLegalOp(bus.opcode)) nxt = 6;
                else begin
                    nxt   = 7;
                    cause = 1;
                end
            end else if (m_st == 6) begin
                nxt = 1;
                m_ret <= (m_ret + 1) % (1 << RW);
            end
            m_wait  <= (nxt == m_st) ? m_wait + 1 : 0;
            m_st    <= nxt;
            m_cause <= cause;
            m_rel   <= 1'b1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("state",          32'(bus.state),          m_st);
            checkOutput("imem_req_valid", 32'(bus.imem_req_valid), 32'(m_st == 1));
            checkOutput("ir_load",        32'(bus.ir_load),        32'((m_st == 2) && (bus.imem_rsp_valid === 1'b1)));
            checkOutput("lsu_req_valid",  32'(bus.lsu_req_valid),  32'(m_st == 4));
            checkOutput("pc_write",       32'(bus.pc_write),       32'(m_st == 6));
            checkOutput("retire",         32'(bus.retire),         32'(m_st == 6));
            checkOutput("halt",           32'(bus.halt),           32'(m_st == 7));
            checkOutput("halt_cause",     32'(bus.halt_cause),     m_cause);
            checkOutput("retire_count",   32'(bus.retire_count),   m_ret);
        end
    end

    // Asserts reset right now, checks the asynchronous clear, then releases
    // it just after the next rising edge.
    task automatic assertResetNow();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_state",         32'(bus.state),          0);
        checkOutput("rst_imem_req_valid", 32'(bus.imem_req_valid), 0);
        checkOutput("rst_lsu_req_valid", 32'(bus.lsu_req_valid),  0);
        checkOutput("rst_retire_count",  32'(bus.retire_count),   0);
        checkOutput("rst_halt_cause",    32'(bus.halt_cause),     0);
        checkOutput("rst_halt",          32'(bus.halt),           0);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #3;
        assertResetNow();
    endtask

    task automatic waitState(input int s, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (bus.state == 3'(s)) found = 1'b1;
        end
        checkOutput(name, 32'(bus.state), s);
    endtask

    initial begin
        int exp_seq [20] = '{1, 2, 3, 6, 1, 2, 3, 4, 5, 6, 1, 2, 3, 4, 5, 6, 1, 2, 3, 6};
        logic [6:0] prog [4] = '{OP_ADDI, OP_LW, OP_SW, OP_JAL};
        int k;
        int cnt;
        int bad;

        applyStimulus(OP_ADDI, 1'b1, 1'b1, 1'b1, 1'b1);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Zero-wait program ADDI, LW, SW, JAL: literal state trace.
        $display("[TB] zero-wait program");
        pulseReset();
        waitState(1, "prog_first_fetch");
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("prog_state_seq", 32'(bus.state), exp_seq[i]);
            if (bus.state == 3'd6 && k < 3) begin
                k++;
                @(posedge clk);
                #2 bus.opcode = prog[k];
            end
        end
        @(negedge clk);
        checkOutput("prog_retire_count", 32'(bus.retire_count), 4);

        // Fetch request stalled three cycles; ready arrives in the last
        // allowed cycle, so the handshake wins.
        $display("[TB] fetch request stall");
        applyStimulus(OP_ADDI, 1'b0, 1'b1, 1'b1, 1'b1);
        pulseReset();
        waitState(1, "stall_fetch_req");
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_req_valid_held", 32'(bus.imem_req_valid), 1);
            @(posedge clk);
            #2;
        end
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        checkOutput("stall_req_valid_4th", 32'(bus.imem_req_valid), 1);
        @(negedge clk);
        checkOutput("stall_to_fetch_wait", 32'(bus.state), 2);
        checkOutput("stall_no_halt", 32'(bus.halt), 0);

        // Illegal opcode halts with cause 01 and stays halted.
        $display("[TB] illegal opcode");
        applyStimulus(OP_SYS, 1'b1, 1'b1, 1'b1, 1'b1);
        pulseReset();
        waitState(3, "illegal_decode");
        @(negedge clk);
        checkOutput("illegal_state", 32'(bus.state), 7);
        checkOutput("illegal_halt", 32'(bus.halt), 1);
        checkOutput("illegal_cause", 32'(bus.halt_cause), 1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2 applyStimulus(7'($urandom_range(0, 127)), 1'($urandom), 1'($urandom),
                             1'($urandom), 1'($urandom));
            @(negedge clk);
            if (bus.state != 3'd7) bad++;
        end
        checkOutput("illegal_halt_held", bad, 0);

        // LSU response never arrives: four MEM_WAIT cycles then cause 11.
        $display("[TB] lsu timeout");
        applyStimulus(OP_LW, 1'b1, 1'b1, 1'b1, 1'b0);
        pulseReset();
        waitState(5, "tmo_mem_wait");
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.state != 3'd5) break;
            cnt++;
        end
        checkOutput("tmo_mem_wait_cycles", cnt, 4);
        checkOutput("tmo_state", 32'(bus.state), 7);
        checkOutput("tmo_cause", 32'(bus.halt_cause), 3);

        // LSU response in the fourth MEM_WAIT cycle: writeback, no halt.
        $display("[TB] lsu response on last cycle");
        applyStimulus(OP_SW, 1'b1, 1'b1, 1'b1, 1'b0);
        pulseReset();
        waitState(5, "late_mem_wait");
        repeat (3) @(posedge clk);
        #2 bus.lsu_rsp_valid = 1'b1;
        @(negedge clk);
        checkOutput("late_still_wait", 32'(bus.state), 5);
        @(negedge clk);
        checkOutput("late_writeback", 32'(bus.state), 6);
        checkOutput("late_no_halt", 32'(bus.halt), 0);

        // Reset in the middle of MEM_REQ clears everything immediately.
        $display("[TB] reset during mem request");
        applyStimulus(OP_SW, 1'b1, 1'b1, 1'b0, 1'b1);
        pulseReset();
        waitState(4, "midrst_mem_req");
        checkOutput("midrst_lsu_valid_before", 32'(bus.lsu_req_valid), 1);
        #2;
        assertResetNow();
        bus.lsu_req_ready = 1'b1;
        @(posedge clk);
        #1 checkOutput("release_edge1_state", 32'(bus.state), 0);
        @(posedge clk);
        #1 checkOutput("release_edge2_state", 32'(bus.state), 1);
        waitState(6, "midrst_resume_writeback");
        checkOutput("midrst_no_halt", 32'(bus.halt), 0);

        // Sixteen retirements wrap the 4-bit counter from 15 back to 0.
        $display("[TB] retire counter wrap");
        applyStimulus(OP_ADDI, 1'b1, 1'b1, 1'b1, 1'b1);
        pulseReset();
        for (int n = 1; n <= 16; n++) begin
            waitState(6, "wrap_writeback");
            @(negedge clk);
            checkOutput("wrap_retire_count", 32'(bus.retire_count), n % 16);
        end

        // Randomized run against the model; any halt is cleared by reset.
        $display("[TB] randomized run");
        pulseReset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [6:0] op;
            int r;
            r = $urandom_range(0, 15);
            op = (r < 2) ? 7'($urandom_range(0, 127)) : legal_ops[r % 9];
            @(posedge clk);
            #2 applyStimulus(op,
                             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
            if (bus.halt) pulseReset();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
